// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo-N counter family.
package counter_pkg;

   localparam logic DIR_UP        = 1'b0;
   localparam logic DIR_DOWN      = 1'b1;
   localparam int   DEFAULT_WIDTH = 4;

endpackage

// File: rtl/counter_next_value.sv
// Combinational successor logic: free-run next value, terminal detect and
// out-of-range detect for the current count against the terminal value M.
module counter_next_value
   import counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] out,
   input  logic [WIDTH-1:0] mod_value,
   input  logic             down,
   output logic [WIDTH-1:0] next,
   output logic             at_end,
   output logic             out_of_range
);

   // Wrap is decided by comparing against M, never by natural 2**WIDTH rollover;
   // an out-of-range count snaps to the start value of the current direction.
   always_comb begin
      out_of_range = (out > mod_value);
      at_end       = 1'b0;
      next         = out;
      if (down == DIR_DOWN) begin
         at_end = (out == '0);
         if (out_of_range || at_end)
            next = mod_value;
         else
            next = out - WIDTH'(1);
      end else begin
         at_end = (out == mod_value);
         if (out_of_range || at_end)
            next = '0;
         else
            next = out + WIDTH'(1);
      end
   end

endmodule

// File: rtl/counter_updown_mod_n.sv
// Synchronous up/down modulo-N counter with enable, parallel load,
// one-shot/free-run mode and cascade carry.
module counter_updown_mod_n
   import counter_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             down,
   input  logic             oneshot,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] mod_value,
   output logic [WIDTH-1:0] out,
   output logic             loop_start,
   output logic             loop_end,
   output logic             carry_out,
   output logic             done
);

   localparam logic [WIDTH-1:0] RESET_OUT = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] next_val;
   logic             at_end;
   logic             out_of_range;

   counter_next_value #(
      .WIDTH(WIDTH)
   ) u_next (
      .out          (out),
      .mod_value    (mod_value),
      .down         (down),
      .next         (next_val),
      .at_end       (at_end),
      .out_of_range (out_of_range)
   );

   // Priority: reset > load > step > hold. A one-shot counter at its end value
   // freezes and raises done; only load or reset releases it.
   always_ff @(posedge clk) begin
      if (reset) begin
         out  <= RESET_OUT;
         done <= 1'b0;
      end else if (load) begin
         out  <= load_value;
         done <= 1'b0;
      end else if (enable && !done) begin
         if (at_end && oneshot && !out_of_range)
            done <= 1'b1;
         else
            out <= next_val;
      end
   end

   assign loop_end   = at_end;
   assign loop_start = (down == DIR_UP) ? (out == '0) : (out == mod_value);
   assign carry_out  = at_end & enable & ~done & ~load;

endmodule

// File: tb/tb_counter_updown_mod_n.sv
// Self-checking bench: directed vector table, hand sequences, randomized run
// against a behavioural model, and a two-stage cascade.
module tb_counter_updown_mod_n;

   logic       clk = 1'b0;
   logic       reset, enable, down, oneshot, load;
   logic [3:0] load_value, mod_value;
   logic [3:0] out;
   logic       loop_start, loop_end, carry_out, done;

   logic       cas_reset, cas_en;
   logic [3:0] lo_out, hi_out;
   logic       lo_ls, lo_le, lo_co, lo_done;
   logic       hi_ls, hi_le, hi_co, hi_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   counter_updown_mod_n #(.WIDTH(4), .RESET_VAL(0)) dut (
      .clk(clk), .reset(reset), .enable(enable), .down(down), .oneshot(oneshot),
      .load(load), .load_value(load_value), .mod_value(mod_value), .out(out),
      .loop_start(loop_start), .loop_end(loop_end), .carry_out(carry_out), .done(done)
   );

   counter_updown_mod_n #(.WIDTH(4), .RESET_VAL(0)) lower (
      .clk(clk), .reset(cas_reset), .enable(cas_en), .down(1'b0), .oneshot(1'b0),
      .load(1'b0), .load_value(4'd0), .mod_value(4'd9), .out(lo_out),
      .loop_start(lo_ls), .loop_end(lo_le), .carry_out(lo_co), .done(lo_done)
   );

   counter_updown_mod_n #(.WIDTH(4), .RESET_VAL(0)) upper (
      .clk(clk), .reset(cas_reset), .enable(lo_co), .down(1'b0), .oneshot(1'b0),
      .load(1'b0), .load_value(4'd0), .mod_value(4'd9), .out(hi_out),
      .loop_start(hi_ls), .loop_end(hi_le), .carry_out(hi_co), .done(hi_done)
   );

   typedef struct {
      logic       rst, en, dn, os, ld;
      logic [3:0] lv, mv;
      logic       chk, ls, le, co;
      logic [3:0] exp_out;
      logic       exp_done;
   } vec_t;

   vec_t vecs[$];

   // Behavioural reference state for the randomized phase
   int m_out, m_done;

   task automatic applyStimulus(input logic r, e, d, o, l, input logic [3:0] lv, mv);
      @(negedge clk);
      reset = r; enable = e; down = d; oneshot = o; load = l;
      load_value = lv; mod_value = mv;
      #1;
   endtask

   task automatic clockEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model next state from the rules: wrap over 0..M by modular arithmetic on M+1
   task automatic modelStep();
      int m, e_val;
      m     = int'(mod_value);
      e_val = down ? 0 : m;
      if (reset) begin
         m_out = 0; m_done = 0;
      end else if (load) begin
         m_out = int'(load_value); m_done = 0;
      end else if (enable && m_done == 0) begin
         if (m_out > m)
            m_out = down ? m : 0;
         else if (m_out == e_val && oneshot)
            m_done = 1;
         else if (down)
            m_out = (m_out + m) % (m + 1);
         else
            m_out = (m_out + 1) % (m + 1);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; down = 1'b0; oneshot = 1'b0; load = 1'b0;
      load_value = '0; mod_value = '0;
      cas_reset = 1'b1; cas_en = 1'b0;

      //              rst en dn os ld  lv     mv    chk ls le co  out    done
      vecs.push_back('{1, 1, 0, 0, 0, 4'd0,  4'd5, 0, 0, 0, 0, 4'd0,  0});
      vecs.push_back('{1, 1, 0, 0, 0, 4'd0,  4'd5, 1, 1, 0, 0, 4'd0,  0});
      vecs.push_back('{0, 1, 0, 0, 0, 4'd0,  4'd5, 1, 1, 0, 0, 4'd1,  0});
      vecs.push_back('{0, 1, 0, 0, 0, 4'd0,  4'd5, 1, 0, 0, 0, 4'd2,  0});
      vecs.push_back('{0, 1, 0, 0, 0, 4'd0,  4'd5, 1, 0, 0, 0, 4'd3,  0});
      vecs.push_back('{0, 1, 0, 0, 0, 4'd0,  4'd5, 1, 0, 0, 0, 4'd4,  0});
      vecs.push_back('{0, 1, 0, 0, 0, 4'd0,  4'd5, 1, 0, 0, 0, 4'd5,  0});
      vecs.push_back('{0, 1, 0, 0, 0, 4'd0,  4'd5, 1, 0, 1, 1, 4'd0,  0});
      vecs.push_back('{0, 1, 1, 0, 0, 4'd0,  4'd5, 1, 0, 1, 1, 4'd5,  0});
      vecs.push_back('{0, 1, 1, 0, 0, 4'd0,  4'd5, 1, 1, 0, 0, 4'd4,  0});
      vecs.push_back('{0, 1, 1, 0, 0, 4'd0,  4'd5, 1, 0, 0, 0, 4'd3,  0});
      vecs.push_back('{0, 1, 1, 0, 0, 4'd0,  4'd5, 1, 0, 0, 0, 4'd2,  0});
      vecs.push_back('{0, 1, 1, 0, 0, 4'd0,  4'd5, 1, 0, 0, 0, 4'd1,  0});
      vecs.push_back('{0, 1, 1, 0, 0, 4'd0,  4'd5, 1, 0, 0, 0, 4'd0,  0});
      vecs.push_back('{0, 1, 1, 0, 0, 4'd0,  4'd5, 1, 0, 1, 1, 4'd5,  0});
      vecs.push_back('{0, 0, 0, 0, 1, 4'd12, 4'd7, 1, 0, 0, 0, 4'd12, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 4'd0,  4'd7, 1, 0, 0, 0, 4'd0,  0});
      vecs.push_back('{0, 0, 1, 0, 1, 4'd12, 4'd7, 1, 0, 1, 0, 4'd12, 0});
      vecs.push_back('{0, 1, 1, 0, 0, 4'd0,  4'd7, 1, 0, 0, 0, 4'd7,  0});
      vecs.push_back('{0, 1, 0, 0, 1, 4'd9,  4'd7, 1, 0, 1, 0, 4'd9,  0});
      vecs.push_back('{1, 0, 0, 0, 1, 4'd9,  4'd7, 1, 0, 0, 0, 4'd0,  0});

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].dn, vecs[i].os, vecs[i].ld,
                       vecs[i].lv, vecs[i].mv);
         if (vecs[i].chk) begin
            checkOutput($sformatf("vec%0d loop_start", i), {3'b0, loop_start}, {3'b0, vecs[i].ls});
            checkOutput($sformatf("vec%0d loop_end", i),   {3'b0, loop_end},   {3'b0, vecs[i].le});
            checkOutput($sformatf("vec%0d carry_out", i),  {3'b0, carry_out},  {3'b0, vecs[i].co});
         end
         clockEdge();
         checkOutput($sformatf("vec%0d out", i),  out,            vecs[i].exp_out);
         checkOutput($sformatf("vec%0d done", i), {3'b0, done},   {3'b0, vecs[i].exp_done});
      end

      // One-shot up to M=3: stops at 3, done, ignores enable and oneshot toggling
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(0, 1, 0, 1, 0, 4'd0, 4'd3);
         clockEdge();
         checkOutput($sformatf("oneshot step%0d out", k), out, 4'(k));
      end
      applyStimulus(0, 1, 0, 1, 0, 4'd0, 4'd3);
      clockEdge();
      checkOutput("oneshot stop out", out, 4'd3);
      checkOutput("oneshot stop done", {3'b0, done}, 4'd1);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(0, 1, 0, logic'(k % 2 == 0), 0, 4'd0, 4'd3);
         checkOutput("oneshot held carry_out", {3'b0, carry_out}, 4'd0);
         clockEdge();
         checkOutput("oneshot held out", out, 4'd3);
         checkOutput("oneshot held done", {3'b0, done}, 4'd1);
      end
      applyStimulus(0, 1, 0, 1, 1, 4'd1, 4'd3);
      clockEdge();
      checkOutput("oneshot reload out", out, 4'd1);
      checkOutput("oneshot reload done", {3'b0, done}, 4'd0);

      // M == 0: out pinned at 0, both flags high, carry every enabled cycle
      applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd0);
      clockEdge();
      checkOutput("m0 snap out", out, 4'd0);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(0, 1, logic'(k), 0, 0, 4'd0, 4'd0);
         checkOutput("m0 loop_start", {3'b0, loop_start}, 4'd1);
         checkOutput("m0 loop_end", {3'b0, loop_end}, 4'd1);
         checkOutput("m0 carry_out", {3'b0, carry_out}, 4'd1);
         clockEdge();
         checkOutput("m0 out", out, 4'd0);
      end

      // Randomized run against the behavioural model
      m_out = 0; m_done = 0;
      for (int n = 0; n < 400; n++) begin
         logic r, e, d, o, l;
         logic [3:0] lv, mv;
         int m, s_val, e_val;
         r  = (n == 0) || ($urandom_range(31) == 0);
         l  = ($urandom_range(7) == 0);
         e  = ($urandom_range(3) != 0);
         d  = ($urandom_range(7) == 0) ? ~down : down;
         o  = logic'($urandom_range(1));
         lv = 4'($urandom_range(15));
         mv = ($urandom_range(15) == 0) ? 4'($urandom_range(15)) : mod_value;
         applyStimulus(r, e, d, o, l, lv, mv);
         m     = int'(mv);
         s_val = d ? m : 0;
         e_val = d ? 0 : m;
         if (n > 0) begin
            checkOutput("rand loop_start", {3'b0, loop_start}, {3'b0, logic'(m_out == s_val)});
            checkOutput("rand loop_end", {3'b0, loop_end}, {3'b0, logic'(m_out == e_val)});
            checkOutput("rand carry_out", {3'b0, carry_out},
                        {3'b0, logic'(m_out == e_val && e && m_done == 0 && !l)});
         end
         modelStep();
         clockEdge();
         checkOutput("rand out", out, 4'(m_out));
         checkOutput("rand done", {3'b0, done}, 4'(m_done));
      end

      // Cascade of two M=9 counters via carry_out
      @(negedge clk);
      cas_reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cas_reset = 1'b0; cas_en = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("cascade15 lower", lo_out, 4'd5);
      checkOutput("cascade15 upper", hi_out, 4'd1);
      repeat (85) @(posedge clk);
      #1;
      @(negedge clk);
      cas_en = 1'b0;
      #1;
      checkOutput("cascade100 lower", lo_out, 4'd0);
      checkOutput("cascade100 upper", hi_out, 4'd0);
      checkOutput("cascade lower loop_start", {3'b0, lo_ls}, 4'd1);
      checkOutput("cascade lower loop_end", {3'b0, lo_le}, 4'd0);
      checkOutput("cascade upper loop_start", {3'b0, hi_ls}, 4'd1);
      checkOutput("cascade upper loop_end", {3'b0, hi_le}, 4'd0);
      checkOutput("cascade upper carry_out", {3'b0, hi_co}, 4'd0);
      checkOutput("cascade done", {2'b0, lo_done, hi_done}, 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
